// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
// Used by sync_fifo users and the inst_fetch_queue top.
package fetch_pkg;

    localparam int FETCH_AW = 32;
    localparam int FETCH_IW = 32;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
    localparam logic [31:0] INST_NOP         = 32'h0340_0000;

    typedef struct packed {
        logic [FETCH_AW-1:0] pc;
        logic [FETCH_IW-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear and occupancy count.
// Pop data is the current head (show-ahead).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign pop_data = mem[rd_ptr];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);

    // Pointer and occupancy bookkeeping; clear drops all contents.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array, no reset needed since count gates visibility.
    always_ff @(posedge clock) begin
        if (push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch PC owner, pipelined iram requester and instruction queue.
// Optional FETCH_BYPASS_EN: empty-queue responses reach decode same cycle.
module inst_fetch_queue
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int INST_WIDTH      = 32,
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] flush_pc,
    output logic [ADDR_WIDTH-1:0] bpu_pc,
    input  logic                  predict_branch,
    input  logic [ADDR_WIDTH-1:0] predict_pc,
    output logic                  iram_rd_en,
    output logic [ADDR_WIDTH-1:0] iram_rd_addr,
    input  logic                  iram_req_ready,
    input  logic                  iram_rd_valid,
    input  logic [INST_WIDTH-1:0] iram_rd_data,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [INST_WIDTH-1:0] out_inst,
    input  logic                  out_ready
);

    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int QW = $clog2(DEPTH) + 1;
    localparam int SW = CW + QW;
    localparam int EW = ADDR_WIDTH + INST_WIDTH;

    logic [ADDR_WIDTH-1:0] pc;
    logic [CW-1:0]         live;
    logic [CW-1:0]         discard;
    logic [CW-1:0]         in_flight;
    logic [CW-1:0]         discard_flush;
    logic [QW-1:0]         count;
    logic [ADDR_WIDTH-1:0] tag_head;
    logic [EW-1:0]         q_in;
    logic [EW-1:0]         q_head;
    logic [EW-1:0]         head;
    logic                  tag_full;
    logic                  tag_empty;
    logic                  q_full;
    logic                  q_empty;
    logic                  credit_ok;
    logic                  accept;
    logic                  resp_keep;
    logic                  bypass;
    logic                  q_push;
    logic                  q_pop;

    // Credits: bound RAM reads in flight and reserve a queue slot for each.
    assign credit_ok = (SW'(live) + SW'(discard) < SW'(MAX_OUTSTANDING))
                    && (SW'(count) + SW'(live) < SW'(DEPTH));

    assign iram_rd_en   = !reset && !flush && credit_ok;
    assign iram_rd_addr = pc;
    assign bpu_pc       = pc;
    assign accept       = iram_rd_en && iram_req_ready;

    assign resp_keep = iram_rd_valid && (discard == '0) && !flush && !reset;
    assign q_in      = {tag_head, iram_rd_data};

`ifdef FETCH_BYPASS_EN
    assign bypass = resp_keep && q_empty;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = !reset && (!q_empty || bypass);
    assign q_pop     = out_valid && out_ready && !q_empty && !flush;
    assign q_push    = resp_keep && !(bypass && out_ready);

    // Head comes from the queue, or from the live response when bypassing.
    always_comb begin
        head = q_empty ? q_in : q_head;
    end

    assign out_pc   = out_valid ? head[EW-1:INST_WIDTH] : '0;
    assign out_inst = out_valid ? head[INST_WIDTH-1:0]  : '0;

    // Everything unanswered at flush time becomes a discard,
    // minus the response that lands in the flush cycle itself.
    assign in_flight     = live + discard;
    assign discard_flush = (iram_rd_valid && in_flight != '0)
                         ? in_flight - CW'(1) : in_flight;

    // Fetch PC sequencing and stale-response accounting.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc      <= RESET_PC;
            discard <= '0;
        end else if (flush) begin
            pc      <= flush_pc;
            discard <= discard_flush;
        end else begin
            if (accept) begin
                pc <= predict_branch ? predict_pc
                                     : pc + ADDR_WIDTH'(4);
            end
            if (iram_rd_valid && discard != '0) begin
                discard <= discard - CW'(1);
            end
        end
    end

    sync_fifo #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (flush),
        .push      (accept),
        .push_data (pc),
        .pop       (resp_keep),
        .pop_data  (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (live)
    );

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_inst_queue (
        .clock     (clock),
        .reset     (reset),
        .clear     (flush),
        .push      (q_push),
        .push_data (q_in),
        .pop       (q_pop),
        .pop_data  (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (count)
    );

    a_no_orphan_rsp: assert property (@(posedge clock) disable iff (reset)
        !(iram_rd_valid && tag_empty && discard == '0));

    a_tag_no_ovf: assert property (@(posedge clock) disable iff (reset)
        !(accept && tag_full));

    a_q_no_ovf: assert property (@(posedge clock) disable iff (reset)
        !(q_push && q_full && !q_pop));

endmodule
